mesh_egress_collector: RTL and testbench

MESH_EGRESS_COLLECTOR -- requirements
Module: mesh_egress_collector

---
 rtl/mesh_egress_collector.sv | 165 ++++++++++++++++
 tb/tb_mesh_egress_collector.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_egress_collector.sv
// Collects packets from NUM_PORTS mesh terminals into per-port FIFOs and merges them
// round-robin into one output register. Optional macro MESH_COLLECT_TSTAMP_EN adds pop-time stamps.
module mesh_egress_collector #(
   parameter int PCKG_SZ    = 40,
   parameter int NUM_PORTS  = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int PORT_W     = $clog2(NUM_PORTS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_PORTS-1:0]         pndng,
   input  logic [NUM_PORTS*PCKG_SZ-1:0] data_out,
   output logic [NUM_PORTS-1:0]         pop,
   output logic [PCKG_SZ-1:0]           out_data,
   output logic [PORT_W-1:0]            out_src,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_PORTS-1:0]         fifo_full,
`ifdef MESH_COLLECT_TSTAMP_EN
   output logic [31:0]                  out_tstamp,
`endif
   output logic [15:0]                  pkt_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_V = PW'(FIFO_DEPTH);

   logic [NUM_PORTS-1:0]              pop_q, pop_d, rd, empty;
   logic [NUM_PORTS-1:0][PCKG_SZ-1:0] head;
   logic                              out_valid_q, out_valid_d;
   logic [PCKG_SZ-1:0]                out_data_q, out_data_d;
   logic [PORT_W-1:0]                 out_src_q, out_src_d;
   logic [PORT_W-1:0]                 rr_q, rr_d, sel;
   logic                              found, ld;
   logic [15:0]                       pkt_cnt_q, pkt_cnt_d;
   logic [16:0]                       cnt_sum;
   int                                idx;
`ifdef MESH_COLLECT_TSTAMP_EN
   logic [31:0]                       tstamp_q;
   logic [31:0]                       out_ts_q, out_ts_d;
   logic [NUM_PORTS-1:0][31:0]        head_ts;
`endif

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      logic [PCKG_SZ-1:0] mem_q [FIFO_DEPTH];
      logic [PW-1:0]      wptr_q, rptr_q, occ;

      assign occ          = wptr_q - rptr_q;
      assign empty[g]     = (occ == '0);
      assign fifo_full[g] = (occ == DEPTH_V);
      // The write launched by the current pop has not landed yet, so it must count as occupied.
      assign pop_d[g]     = pndng[g] & ~pop_q[g] & ((occ + PW'(pop_q[g])) < DEPTH_V);
      assign head[g]      = mem_q[rptr_q[AW-1:0]];

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            wptr_q <= wptr_q + PW'(pop_q[g]);
            rptr_q <= rptr_q + PW'(rd[g]);
         end
      end

      always_ff @(posedge clk) begin
         if (pop_q[g]) mem_q[wptr_q[AW-1:0]] <= data_out[g*PCKG_SZ +: PCKG_SZ];
      end

`ifdef MESH_COLLECT_TSTAMP_EN
      logic [31:0] ts_q [FIFO_DEPTH];
      assign head_ts[g] = ts_q[rptr_q[AW-1:0]];
      always_ff @(posedge clk) begin
         if (pop_q[g]) ts_q[wptr_q[AW-1:0]] <= tstamp_q;
      end
`endif
   end

   // Round-robin search for the first non-empty FIFO starting at rr_q.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NUM_PORTS; off++) begin
         idx = int'(rr_q) + off;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            sel   = PORT_W'(idx);
         end
      end
   end

   assign ld = found & (~out_valid_q | out_ready);

   always_comb begin
      rd = '0;
      if (ld) rd[sel] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_d        = rr_q;
`ifdef MESH_COLLECT_TSTAMP_EN
      out_ts_d    = out_ts_q;
`endif
      if (ld) begin
         out_valid_d = 1'b1;
         out_data_d  = head[sel];
         out_src_d   = sel;
         rr_d        = (sel == PORT_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
`ifdef MESH_COLLECT_TSTAMP_EN
         out_ts_d    = head_ts[sel];
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      cnt_sum = {1'b0, pkt_cnt_q};
      for (int i = 0; i < NUM_PORTS; i++) cnt_sum = cnt_sum + 17'(pop_q[i]);
      pkt_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pop_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         rr_q        <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         pop_q       <= pop_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_q        <= rr_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

`ifdef MESH_COLLECT_TSTAMP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tstamp_q <= '0;
         out_ts_q <= '0;
      end else begin
         tstamp_q <= tstamp_q + 32'd1;
         out_ts_q <= out_ts_d;
      end
   end
   assign out_tstamp = out_ts_q;
`endif

   assign pop       = pop_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_mesh_egress_collector.sv
// Bench for mesh_egress_collector: directed scenarios plus randomized mesh traffic
// scored against per-port packet queues.
`timescale 1ns/100ps
module tb_mesh_egress_collector;

   localparam int NP = 16;
   localparam int PS = 40;

   logic           clk = 1'b0;
   logic           reset;
   logic [NP-1:0]  pndng;
   logic [NP*PS-1:0] data_out;
   logic [NP-1:0]  pop;
   logic [PS-1:0]  out_data;
   logic [3:0]     out_src;
   logic           out_valid;
   logic           out_ready;
   logic [NP-1:0]  fifo_full;
   logic [15:0]    pkt_cnt;
`ifdef MESH_COLLECT_TSTAMP_EN
   logic [31:0]    out_tstamp;
`endif

   int n_pass = 0;
   int n_total = 0;
   int pops_done = 0;
   logic [PS-1:0] srcq [NP][$];
   logic [PS-1:0] expq [NP][$];

   mesh_egress_collector dut (
      .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_full(fifo_full),
`ifdef MESH_COLLECT_TSTAMP_EN
      .out_tstamp(out_tstamp),
`endif
      .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic do_reset();
      reset = 1'b0; pndng = '0; data_out = '0; out_ready = 1'b0;
      for (int i = 0; i < NP; i++) begin srcq[i].delete(); expq[i].delete(); end
      pops_done = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic apply_mesh(input bit gate);
      for (int i = 0; i < NP; i++) begin
         pndng[i] = (srcq[i].size() > 0) && (!gate || $urandom_range(0, 3) != 0);
         data_out[i*PS +: PS] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
      end
   endtask

   // Mesh emulator + scoreboard: packets leave srcq on pop, must come out in per-port order.
   task automatic run_traffic(input int max_cycles, input int ready_mode, input bit check_alt, input bit gate);
      logic [NP-1:0] p, prev_p;
      logic v, r, prev_v, prev_r;
      logic [PS-1:0] d, prev_d;
      logic [3:0] s, prev_s;
      int last_s, cyc, left;
      bit fin;
      prev_p = '0; prev_v = 0; prev_r = 0; prev_d = '0; prev_s = '0;
      last_s = -1; cyc = 0; fin = 0;
      apply_mesh(gate);
      out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!fin) begin
         @(negedge clk);
         p = pop; v = out_valid; r = out_ready; d = out_data; s = out_src;
         n_total++;
         if ((p & prev_p) != '0 || (p & fifo_full) != '0)
            $display("FAIL pop_spacing: pop=%h prev_pop=%h fifo_full=%h, required no back-to-back pop and no pop while full", p, prev_p, fifo_full);
         else n_pass++;
         n_total++;
         if (pkt_cnt !== 16'(pops_done)) $display("FAIL pkt_cnt: got %0d expected %0d", pkt_cnt, pops_done);
         else n_pass++;
         if (prev_v && !prev_r) begin
            n_total++;
            if (!v || d !== prev_d || s !== prev_s)
               $display("FAIL stall_hold: got v=%b d=%h s=%0d expected v=1 d=%h s=%0d", v, d, s, prev_d, prev_s);
            else n_pass++;
         end
         if (v && r) begin
            n_total++;
            if (expq[s].size() == 0) $display("FAIL deliver: got src=%0d data=%h expected no packet from that port", s, d);
            else begin
               if (d !== expq[s][0]) $display("FAIL deliver: src=%0d got %h expected %h", s, d, expq[s][0]);
               else n_pass++;
               void'(expq[s].pop_front());
            end
            if (check_alt) begin
               if (last_s >= 0) begin
                  n_total++;
                  if (int'(s) == last_s) $display("FAIL alternate: got src %0d expected src other than %0d", s, last_s);
                  else n_pass++;
               end
               last_s = int'(s);
            end
         end
         for (int i = 0; i < NP; i++) if (p[i]) begin
            if (srcq[i].size() == 0) begin
               n_total++;
               $display("FAIL spurious_pop: port %0d got pop=1 expected 0 (mesh empty)", i);
            end else expq[i].push_back(srcq[i][0]);
         end
         prev_p = p; prev_v = v; prev_r = r; prev_d = d; prev_s = s;
         fin = !v;
         for (int i = 0; i < NP; i++) if (srcq[i].size() != 0 || expq[i].size() != 0) fin = 0;
         @(posedge clk); #1;
         for (int i = 0; i < NP; i++) if (p[i]) begin
            if (srcq[i].size() != 0) void'(srcq[i].pop_front());
            pops_done++;
         end
         apply_mesh(gate);
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = cyc[0];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         cyc++;
         if (!fin && cyc >= max_cycles) begin
            n_total++;
            $display("FAIL traffic_timeout: got %0d cycles without draining, required drain", cyc);
            fin = 1;
         end
      end
      left = 0;
      for (int i = 0; i < NP; i++) left += srcq[i].size() + expq[i].size();
      n_total++;
      if (left != 0) $display("FAIL undelivered: got %0d packets outstanding expected 0", left);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; pndng = '0; data_out = '0; out_ready = 1'b0;
      #1 reset = 1'b0;
      #1;
      n_total++; if (pop !== '0) $display("FAIL rst_pop: got %h expected 0", pop); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (out_data !== '0) $display("FAIL rst_data: got %h expected 0", out_data); else n_pass++;
      n_total++; if (out_src !== '0) $display("FAIL rst_src: got %h expected 0", out_src); else n_pass++;
      n_total++; if (fifo_full !== '0) $display("FAIL rst_full: got %h expected 0", fifo_full); else n_pass++;
      n_total++; if (pkt_cnt !== '0) $display("FAIL rst_cnt: got %h expected 0", pkt_cnt); else n_pass++;
      pndng = '1;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (pop !== '0) $display("FAIL rst_hold_pop: got %h expected 0", pop); else n_pass++;
      @(negedge clk) reset = 1'b1;
      #1;
      n_total++; if (pop !== '0) $display("FAIL release_pop_early: got %h expected 0", pop); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (pop !== '1) $display("FAIL release_first_pop: got %h expected ffff", pop); else n_pass++;
      pndng = '0;
   endtask

   task automatic test_single();
      do_reset();
      pndng = 16'h0008; data_out[3*PS +: PS] = 40'h00_0300_0003; out_ready = 1'b1;
      @(posedge clk); #1;
      n_total++; if (pop !== 16'h0008) $display("FAIL single_pop_c1: got %h expected 0008", pop); else n_pass++;
      pndng = '0;
      @(posedge clk); #1;
      n_total++; if (pop !== '0 || out_valid !== 1'b0) $display("FAIL single_c2: got pop=%h v=%b expected 0,0", pop, out_valid); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid_c3: got %b expected 1", out_valid); else n_pass++;
      n_total++; if (out_data !== 40'h00_0300_0003) $display("FAIL single_data: got %h expected 0003000003", out_data); else n_pass++;
      n_total++; if (out_src !== 4'd3) $display("FAIL single_src: got %0d expected 3", out_src); else n_pass++;
      n_total++; if (pkt_cnt !== 16'd1) $display("FAIL single_cnt: got %0d expected 1", pkt_cnt); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", out_valid); else n_pass++;
   endtask

   task automatic test_alternate();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         srcq[0].push_back({8'd0, 32'($urandom)});
         srcq[1].push_back({8'd1, 32'($urandom)});
      end
      run_traffic(200, 0, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [PS-1:0] base;
      int k, npops, got, bad;
      logic prevpop;
      base = 40'h55_0000_0000; k = 0; npops = 0; got = 0; bad = 0; prevpop = 0;
      do_reset();
      out_ready = 1'b0; pndng[5] = 1'b1; data_out[5*PS +: PS] = base;
      repeat (30) begin
         @(posedge clk); #1;
         if (prevpop) k++;
         data_out[5*PS +: PS] = base + 40'(k);
         if (pop[5]) npops++;
         if (pop[5] && prevpop) bad++;
         prevpop = pop[5];
      end
      n_total++; if (npops != 5) $display("FAIL bp_pops: got %0d expected 5", npops); else n_pass++;
      n_total++; if (fifo_full[5] !== 1'b1) $display("FAIL bp_full: got %b expected 1", fifo_full[5]); else n_pass++;
      n_total++; if (pkt_cnt !== 16'd5) $display("FAIL bp_cnt: got %0d expected 5", pkt_cnt); else n_pass++;
      n_total++; if (out_valid !== 1'b1 || out_data !== base || out_src !== 4'd5)
         $display("FAIL bp_hold: got v=%b d=%h s=%0d expected v=1 d=%h s=5", out_valid, out_data, out_src, base);
      else n_pass++;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && got < 8; c++) begin
         if (out_valid) begin
            n_total++;
            if (out_data !== base + 40'(got)) $display("FAIL bp_order: got %h expected %h", out_data, base + 40'(got));
            else n_pass++;
            got++;
         end
         @(posedge clk); #1;
         if (prevpop) k++;
         data_out[5*PS +: PS] = base + 40'(k);
         if (pop[5]) npops++;
         if (pop[5] && prevpop) bad++;
         prevpop = pop[5];
         if (npops >= 8) pndng[5] = 1'b0;
      end
      n_total++; if (got != 8) $display("FAIL bp_drain: got %0d packets expected 8", got); else n_pass++;
      n_total++; if (bad != 0) $display("FAIL bp_spacing: got %0d back-to-back pops expected 0", bad); else n_pass++;
   endtask

   task automatic test_all_ports();
      do_reset();
      for (int i = 0; i < NP; i++)
         repeat ($urandom_range(4, 8)) srcq[i].push_back({8'(i), 32'($urandom)});
      run_traffic(2000, 1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < NP; i++)
         if ($urandom_range(0, 2) != 0)
            repeat ($urandom_range(1, 12)) srcq[i].push_back({8'(i), 32'($urandom)});
      run_traffic(3000, 2, 1'b0, 1'b1);
   endtask

   task automatic test_reset_midburst();
      bit seen;
      do_reset();
      out_ready = 1'b0;
      pndng = 16'h0084;
      data_out[2*PS +: PS] = 40'h22_2222_2222;
      data_out[7*PS +: PS] = 40'h77_7777_7777;
      for (int c = 0; c < 20 && pkt_cnt < 16'd3; c++) begin @(posedge clk); #1; end
      n_total++; if (pkt_cnt < 16'd3) $display("FAIL mid_fill: got pkt_cnt %0d expected >=3", pkt_cnt); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", out_valid); else n_pass++;
      #3 reset = 1'b0; pndng = '0;
      #0.5;
      n_total++; if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0)
         $display("FAIL mid_async_out: got v=%b d=%h s=%0d expected 0,0,0", out_valid, out_data, out_src);
      else n_pass++;
      n_total++; if (pop !== '0 || fifo_full !== '0 || pkt_cnt !== '0)
         $display("FAIL mid_async_state: got pop=%h full=%h cnt=%0d expected 0,0,0", pop, fifo_full, pkt_cnt);
      else n_pass++;
      #0.5 reset = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid || pop != '0) seen = 1;
      end
      n_total++; if (seen) $display("FAIL mid_stale: got activity after reset expected none"); else n_pass++;
   endtask

`ifdef MESH_COLLECT_TSTAMP_EN
   task automatic test_tstamp();
      int c;
      do_reset();
      out_ready = 1'b1;
      repeat (98) @(posedge clk);
      #1;
      pndng[0] = 1'b1; data_out[0 +: PS] = 40'h12_3456_789A;
      @(posedge clk); #1;
      pndng[0] = 1'b0;
      c = 0;
      while (!out_valid && c < 10) begin @(posedge clk); #1; c++; end
      n_total++; if (!out_valid) $display("FAIL ts_timeout: got no output expected one"); else n_pass++;
      n_total++; if (out_tstamp !== 32'd100) $display("FAIL ts_value: got %0d expected 100", out_tstamp); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_all_ports();
      test_random();
      test_reset_midburst();
`ifdef MESH_COLLECT_TSTAMP_EN
      test_tstamp();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
